// File: rtl/boot_pkg.sv
`default_nettype none
//============================================================================
// Module      : boot_pkg
// Description : Shared definitions for the serial boot loader: FSM state
//               encoding, stream header length and word geometry.
// Revision    : 1.0 - initial release
//============================================================================
package boot_pkg;

    // Loader FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        HDR0 = 3'd0,    // expecting count high byte
        HDR1 = 3'd1,    // expecting count low byte
        DATA = 3'd2,    // receiving image bytes
        CSUM = 3'd3,    // expecting checksum byte
        DONE = 3'd4,    // image loaded and verified
        ERR  = 3'd5     // load failed
    } boot_state_t;

    // Number of header bytes carrying the word count.
    localparam int unsigned c_hdr_bytes      = 2;
    // Bytes assembled into each memory word.
    localparam int unsigned c_bytes_per_word = 4;

endpackage : boot_pkg
`default_nettype wire

// File: rtl/boot_loader.sv
`default_nettype none
//============================================================================
// Module      : boot_loader
// Description : Receives a byte-stream boot image (16-bit big-endian word
//               count, 4*N big-endian data bytes, XOR checksum byte),
//               writes each assembled word to memory and releases the CPU
//               reset once the checksum verifies.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid/in_data    - byte stream input
//               in_ready            - byte stream ready
//               mem_we/addr/wdata   - single-cycle word write port
//               cpu_rstn            - active-low CPU reset (low while loading)
//               done / err          - load verified / load failed (sticky)
// Revision    : 1.0 - initial release
//============================================================================
module boot_loader
    import boot_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    output logic        in_ready,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_rstn,
    output logic        done,
    output logic        err
);

    localparam int unsigned c_count_w   = 8 * c_hdr_bytes;
    localparam int unsigned c_idx_shift = $clog2(c_bytes_per_word);
    localparam logic [1:0]  c_last_byte = 2'(c_bytes_per_word - 1);
    localparam logic [31:0] c_max_words = 32'(MAX_WORDS);

    boot_state_t            r_state;
    logic [c_count_w-1:0]   r_count;
    logic [c_count_w-1:0]   r_word_idx;
    logic [1:0]             r_byte_cnt;
    logic [23:0]            r_asm;      // first three bytes of the current word
    logic [7:0]             r_csum;
    logic                   r_mem_we;
    logic [31:0]            r_mem_addr;
    logic [31:0]            r_mem_wdata;
    logic                   r_done;
    logic                   r_err;
    logic                   r_cpu_rstn;

    logic                   w_hs;
    logic [c_count_w-1:0]   w_count;

    // Ready is a pure decode of the state register.
    assign in_ready = (r_state == HDR0) || (r_state == HDR1) ||
                      (r_state == DATA) || (r_state == CSUM);
    assign w_hs     = in_valid && in_ready;
    // Full count as seen while the low header byte is on the bus.
    assign w_count  = {r_count[c_count_w-1:8], in_data};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= HDR0;
            r_count     <= '0;
            r_word_idx  <= '0;
            r_byte_cnt  <= '0;
            r_asm       <= '0;
            r_csum      <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_cpu_rstn  <= 1'b0;
        end else begin
            // Write strobe is a one-cycle pulse.
            r_mem_we <= 1'b0;
            case (r_state)
                HDR0: begin
                    if (w_hs) begin
                        r_count[c_count_w-1:8] <= in_data;
                        r_state                <= HDR1;
                    end
                end
                HDR1: begin
                    if (w_hs) begin
                        r_count <= w_count;
                        if (w_count == '0) begin
                            r_state <= CSUM;
                        end else if (32'(w_count) > c_max_words) begin
                            r_state <= ERR;
                        end else begin
                            r_state <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (w_hs) begin
                        r_asm      <= {r_asm[15:0], in_data};
                        r_csum     <= r_csum ^ in_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        if (r_byte_cnt == c_last_byte) begin
                            r_mem_we    <= 1'b1;
                            r_mem_addr  <= BASE_ADDR + (32'(r_word_idx) << c_idx_shift);
                            r_mem_wdata <= {r_asm, in_data};
                            r_word_idx  <= r_word_idx + 1'b1;
                            if (r_word_idx == r_count - 1'b1) begin
                                r_state <= CSUM;
                            end
                        end
                    end
                end
                CSUM: begin
                    if (w_hs) begin
                        r_state <= (in_data == r_csum) ? DONE : ERR;
                    end
                end
                DONE: begin
                    r_done     <= 1'b1;
                    r_cpu_rstn <= 1'b1;
                end
                ERR: begin
                    r_err <= 1'b1;
                end
                default: begin
                    r_state <= ERR;
                end
            endcase
        end
    end

    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign done      = r_done;
    assign err       = r_err;
    assign cpu_rstn  = r_cpu_rstn;

endmodule : boot_loader
`default_nettype wire

// File: tb/tb_boot_loader.sv
`default_nettype none
//============================================================================
// Module      : tb_boot_loader
// Description : Directed self-checking bench for boot_loader.
// Revision    : 1.0 - initial release
//============================================================================
module tb_boot_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        cpu_rstn;
    logic        done;
    logic        err;

    int total;
    int bad;

    // Captured write transactions.
    logic [31:0] wr_addr [$];
    logic [31:0] wr_data [$];
    int          base;

    boot_loader #(
        .BASE_ADDR (32'h0000_0000),
        .MAX_WORDS (1024)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rstn  (cpu_rstn),
        .done      (done),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One entry per cycle that mem_we is high, so a stretched pulse shows
    // up as an extra write.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(mem_addr);
            wr_data.push_back(mem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Presents one byte for exactly one edge after 'gap' idle cycles.
    task automatic send(input logic [7:0] b, input int gap);
        repeat (gap) @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'hxx;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [7:0] s1 [7];
    logic [7:0] s3 [15];
    logic [31:0] w3 [3];

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        s1 = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
        // 3 words; checksum 0x44 ^ 0x0C ^ 0x00 = 0x48
        s3 = '{8'h00, 8'h03, 8'h11, 8'h22, 8'h33, 8'h44, 8'hA5, 8'hB6,
               8'hC7, 8'hD8, 8'h0F, 8'h0E, 8'h0D, 8'h0C, 8'h48};
        w3 = '{32'h1122_3344, 32'hA5B6_C7D8, 32'h0F0E_0D0C};

        // ---- reset state ----
        do_reset();
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_cpu_rstn", 32'(cpu_rstn), 32'd0);

        // ---- single word ----
        base = wr_addr.size();
        for (int i = 0; i < 7; i++) send(s1[i], 0);
        chk("one_done_early", 32'(done), 32'd0);
        chk("one_rstn_early", 32'(cpu_rstn), 32'd0);
        idle(1);
        chk("one_done", 32'(done), 32'd1);
        chk("one_rstn", 32'(cpu_rstn), 32'd1);
        chk("one_err", 32'(err), 32'd0);
        chk("one_ready", 32'(in_ready), 32'd0);
        chk("one_nwr", 32'(wr_addr.size() - base), 32'd1);
        if (wr_addr.size() > base) begin
            chk("one_addr", wr_addr[base], 32'h0);
            chk("one_data", wr_data[base], 32'h1234_5678);
        end
        chk("one_hold_addr", mem_addr, 32'h0);
        chk("one_hold_data", mem_wdata, 32'h1234_5678);

        // ---- empty image ----
        do_reset();
        base = wr_addr.size();
        send(8'h00, 0); send(8'h00, 0); send(8'h00, 0);
        idle(2);
        chk("empty_done", 32'(done), 32'd1);
        chk("empty_err", 32'(err), 32'd0);
        chk("empty_nwr", 32'(wr_addr.size() - base), 32'd0);

        // ---- bad checksum ----
        do_reset();
        base = wr_addr.size();
        for (int i = 0; i < 6; i++) send(s1[i], 0);
        send(8'h09, 0);
        idle(1);
        chk("bad_err", 32'(err), 32'd1);
        chk("bad_done", 32'(done), 32'd0);
        chk("bad_rstn", 32'(cpu_rstn), 32'd0);
        chk("bad_ready", 32'(in_ready), 32'd0);
        chk("bad_nwr", 32'(wr_addr.size() - base), 32'd1);

        // ---- count boundary: exactly MAX_WORDS is accepted ----
        do_reset();
        send(8'h04, 0); send(8'h00, 0);
        idle(2);
        chk("max_err", 32'(err), 32'd0);
        chk("max_ready", 32'(in_ready), 32'd1);

        // ---- oversize ----
        do_reset();
        base = wr_addr.size();
        send(8'h04, 0); send(8'h01, 0);
        chk("over_err_early", 32'(err), 32'd0);
        idle(1);
        chk("over_err", 32'(err), 32'd1);
        chk("over_ready", 32'(in_ready), 32'd0);
        idle(3);
        chk("over_nwr", 32'(wr_addr.size() - base), 32'd0);

        // ---- 3 words, gap-free then with random gaps ----
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            base = wr_addr.size();
            for (int i = 0; i < 15; i++)
                send(s3[i], (pass == 0) ? 0 : int'($urandom_range(0, 4)));
            idle(2);
            chk(pass ? "gap_done" : "nogap_done", 32'(done), 32'd1);
            chk(pass ? "gap_err" : "nogap_err", 32'(err), 32'd0);
            chk(pass ? "gap_nwr" : "nogap_nwr", 32'(wr_addr.size() - base), 32'd3);
            for (int k = 0; k < 3; k++) begin
                if (wr_addr.size() > base + k) begin
                    chk("w3_addr", wr_addr[base + k], 32'(4 * k));
                    chk("w3_data", wr_data[base + k], w3[k]);
                end
            end
            chk("w3_hold_addr", mem_addr, 32'h8);
        end

        // ---- mid-load reset ----
        do_reset();
        send(8'h00, 0); send(8'h02, 0);
        send(8'h12, 0); send(8'h34, 0); send(8'h56, 0);
        send(8'h78, 0); send(8'h9A, 0); send(8'hBC, 0);
        do_reset();
        base = wr_addr.size();
        chk("mid_rst_addr", mem_addr, 32'd0);
        for (int i = 0; i < 7; i++) send(s1[i], 0);
        idle(2);
        chk("mid_nwr", 32'(wr_addr.size() - base), 32'd1);
        if (wr_addr.size() > base) begin
            chk("mid_addr", wr_addr[base], 32'h0);
            chk("mid_data", wr_data[base], 32'h1234_5678);
        end
        chk("mid_done", 32'(done), 32'd1);
        chk("mid_err", 32'(err), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_boot_loader
`default_nettype wire
